mlu_bootstrapper: RTL and testbench

Boot-time loader that drives the MLU bootstrap write interface (BOOTSTRAP_ADDR/BOOTSTRAP_DATA/N_WE strobes/N_BOOTED) from a byte stream.
- After reset it streams SLICE_BYTES bytes into the shared slice ROM image, then LOOKAHEAD_BYTES bytes into the lookahead ROM image.
- It then releases N_BOOTED so the MLU runs from the loaded tables.
- It sits between the boot byte source (serial/flash reader) and the mlu bootstrap ports.

---
 rtl/mlu_bootstrapper.sv | 167 ++++++++++++++++
 tb/tb_mlu_bootstrapper.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlu_bootstrapper.sv
// Boot-time loader: streams bytes into the MLU slice and lookahead ROM images, then releases N_BOOTED.
// Optional trailer checksum verification is enabled with `define MLU_BOOT_CHECKSUM_EN.
module mlu_bootstrapper #(
  parameter int SLICE_BYTES     = 4096,
  parameter int LOOKAHEAD_BYTES = 131072,
  parameter int WE_CYCLES       = 1
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [16:0] BOOTSTRAP_ADDR,
  output logic [7:0]  BOOTSTRAP_DATA,
  output logic        BOOTSTRAP_MLU_SLICE_N_WE,
  output logic        BOOTSTRAP_MLU_LOOKAHEAD_N_WE,
  output logic        N_BOOTED,
  output logic        ERR
);

  localparam logic [17:0] SLICE_N = 18'(SLICE_BYTES);
  localparam logic [17:0] LA_N    = 18'(LOOKAHEAD_BYTES);
  localparam int          WW      = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [WW-1:0] WE_LAST = WW'(WE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_SETUP, S_STROBE, S_HOLD, S_DONE
`ifdef MLU_BOOT_CHECKSUM_EN
    , S_CHECK, S_FAIL
`endif
  } state_t;

`ifdef MLU_BOOT_CHECKSUM_EN
  localparam state_t S_END = S_CHECK;
`else
  localparam state_t S_END = S_DONE;
`endif
  // Entering S_END only releases N_BOOTED when no trailer check follows.
  localparam logic END_N_BOOTED = (S_END != S_DONE);

  state_t        r_state;
  logic          r_phase;
  logic [16:0]   r_cnt;
  logic [WW-1:0] r_we_cnt;
  logic [16:0]   r_addr;
  logic [7:0]    r_data;
  logic          r_slice_n_we;
  logic          r_la_n_we;
  logic          r_n_booted;
  logic [17:0]   w_cnt_inc;
  logic          w_phase_end;
`ifdef MLU_BOOT_CHECKSUM_EN
  logic [7:0]    r_sum;
  logic          r_err;
`endif

  assign w_cnt_inc   = {1'b0, r_cnt} + 18'd1;
  assign w_phase_end = r_phase ? (w_cnt_inc == LA_N) : (w_cnt_inc == SLICE_N);

`ifdef MLU_BOOT_CHECKSUM_EN
  assign IN_READY = (r_state == S_FETCH) || (r_state == S_CHECK);
  assign ERR      = r_err;
`else
  assign IN_READY = (r_state == S_FETCH);
  assign ERR      = 1'b0;
`endif
  assign BOOTSTRAP_ADDR               = r_addr;
  assign BOOTSTRAP_DATA               = r_data;
  assign BOOTSTRAP_MLU_SLICE_N_WE     = r_slice_n_we;
  assign BOOTSTRAP_MLU_LOOKAHEAD_N_WE = r_la_n_we;
  assign N_BOOTED                     = r_n_booted;

  // Load sequencer: fetch byte, set up address/data, strobe, hold, advance.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_state      <= S_INIT;
      r_phase      <= 1'b0;
      r_cnt        <= 17'd0;
      r_we_cnt     <= '0;
      r_addr       <= 17'd0;
      r_data       <= 8'd0;
      r_slice_n_we <= 1'b1;
      r_la_n_we    <= 1'b1;
      r_n_booted   <= 1'b1;
`ifdef MLU_BOOT_CHECKSUM_EN
      r_sum        <= 8'd0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_INIT: begin
          if (SLICE_N != 18'd0) begin
            r_phase <= 1'b0;
            r_state <= S_FETCH;
          end else if (LA_N != 18'd0) begin
            r_phase <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            r_state    <= S_END;
            r_n_booted <= END_N_BOOTED;
          end
        end
        S_FETCH: begin
          if (IN_VALID) begin
            r_data  <= IN_DATA;
            r_addr  <= r_cnt;
            r_state <= S_SETUP;
`ifdef MLU_BOOT_CHECKSUM_EN
            r_sum   <= r_sum + IN_DATA;
`endif
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_SETUP: begin
          r_we_cnt <= '0;
          r_state  <= S_STROBE;
          if (r_phase) begin
            r_la_n_we <= 1'b0;
          end else begin
            r_slice_n_we <= 1'b0;
          end
        end
        S_STROBE: begin
          if (r_we_cnt == WE_LAST) begin
            r_slice_n_we <= 1'b1;
            r_la_n_we    <= 1'b1;
            r_state      <= S_HOLD;
          end else begin
            r_we_cnt <= r_we_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!w_phase_end) begin
            r_cnt   <= w_cnt_inc[16:0];
            r_state <= S_FETCH;
          end else if (!r_phase && (LA_N != 18'd0)) begin
            r_phase <= 1'b1;
            r_cnt   <= 17'd0;
            r_state <= S_FETCH;
          end else begin
            r_cnt      <= w_cnt_inc[16:0];
            r_state    <= S_END;
            r_n_booted <= END_N_BOOTED;
          end
        end
`ifdef MLU_BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (!IN_VALID) begin
            r_state <= S_CHECK;
          end else if (IN_DATA == r_sum) begin
            r_state    <= S_DONE;
            r_n_booted <= 1'b0;
          end else begin
            r_state <= S_FAIL;
            r_err   <= 1'b1;
          end
        end
        S_FAIL:  r_state <= S_FAIL;
`endif
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_mlu_bootstrapper.sv
// Scoreboard bench for mlu_bootstrapper: three instances with different sizes/strobe widths,
// exercised one at a time while the others are held in reset.
module tb_mlu_bootstrapper;

  typedef struct packed {
    logic [1:0]  id;
    logic        slice;
    logic [16:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  n_rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready [3];
  logic [16:0] addr     [3];
  logic [7:0]  data     [3];
  logic        swe      [3];
  logic        lwe      [3];
  logic        nb       [3];
  logic        err      [3];

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   we_exp [3] = '{1, 3, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mlu_bootstrapper #(.SLICE_BYTES(2), .LOOKAHEAD_BYTES(2), .WE_CYCLES(1)) dut0 (
    .CLK(clk), .N_RST(n_rst[0]), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready[0]),
    .BOOTSTRAP_ADDR(addr[0]), .BOOTSTRAP_DATA(data[0]), .BOOTSTRAP_MLU_SLICE_N_WE(swe[0]),
    .BOOTSTRAP_MLU_LOOKAHEAD_N_WE(lwe[0]), .N_BOOTED(nb[0]), .ERR(err[0]));

  mlu_bootstrapper #(.SLICE_BYTES(2), .LOOKAHEAD_BYTES(2), .WE_CYCLES(3)) dut1 (
    .CLK(clk), .N_RST(n_rst[1]), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready[1]),
    .BOOTSTRAP_ADDR(addr[1]), .BOOTSTRAP_DATA(data[1]), .BOOTSTRAP_MLU_SLICE_N_WE(swe[1]),
    .BOOTSTRAP_MLU_LOOKAHEAD_N_WE(lwe[1]), .N_BOOTED(nb[1]), .ERR(err[1]));

  mlu_bootstrapper #(.SLICE_BYTES(0), .LOOKAHEAD_BYTES(1), .WE_CYCLES(1)) dut2 (
    .CLK(clk), .N_RST(n_rst[2]), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready[2]),
    .BOOTSTRAP_ADDR(addr[2]), .BOOTSTRAP_DATA(data[2]), .BOOTSTRAP_MLU_SLICE_N_WE(swe[2]),
    .BOOTSTRAP_MLU_LOOKAHEAD_N_WE(lwe[2]), .N_BOOTED(nb[2]), .ERR(err[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input bit sl, input int a, input int dat);
    exp_t e;
    e.id    = id[1:0];
    e.slice = sl;
    e.addr  = a[16:0];
    e.data  = dat[7:0];
    q.push_back(e);
  endtask

  // Offer a byte and wait (bounded) until the DUT accepts it; t returns the accept cycle.
  task automatic send_byte(input int d, input logic [7:0] b, output int t);
    bit ok;
    ok       = 1'b0;
    t        = 0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        @(posedge clk);
        #1;
        t  = cyc;
        ok = 1'b1;
      end
    end
    chk("accept_in_time", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_booted(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!nb[d]) ok = 1'b1;
    end
    chk("booted_in_time", {31'd0, ok}, 32'd1);
  endtask

  // Write monitor: pops the scoreboard on each strobe fall and checks pulse width/stability.
  initial begin
    logic        p_s  [3];
    logic        p_l  [3];
    int          lowc [3];
    logic [16:0] pa   [3];
    logic [7:0]  pd   [3];
    logic [16:0] sa   [3];
    logic [7:0]  sd   [3];
    exp_t        e;
    for (int d = 0; d < 3; d++) begin
      p_s[d] = 1'b1; p_l[d] = 1'b1; lowc[d] = 0; pa[d] = '0; pd[d] = '0; sa[d] = '0; sd[d] = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!n_rst[d]) begin
          p_s[d] = 1'b1; p_l[d] = 1'b1; lowc[d] = 0;
        end else begin
          chk("we_exclusive", {31'd0, swe[d] | lwe[d]}, 32'd1);
          if ((!swe[d] && p_s[d]) || (!lwe[d] && p_l[d])) begin
            chk("wr_pending", {31'd0, q.size() > 0}, 32'd1);
            if (q.size() > 0) begin
              e = q.pop_front();
              chk("wr_dut", d, {30'd0, e.id});
              chk("wr_is_slice", {31'd0, ~swe[d]}, {31'd0, e.slice});
              chk("wr_addr", {15'd0, addr[d]}, {15'd0, e.addr});
              chk("wr_data", {24'd0, data[d]}, {24'd0, e.data});
            end
            chk("wr_setup_addr", {15'd0, addr[d]}, {15'd0, pa[d]});
            chk("wr_setup_data", {24'd0, data[d]}, {24'd0, pd[d]});
            lowc[d] = 1; sa[d] = addr[d]; sd[d] = data[d];
          end else if (!swe[d] || !lwe[d]) begin
            lowc[d]++;
            chk("wr_low_addr", {15'd0, addr[d]}, {15'd0, sa[d]});
          end else if (!p_s[d] || !p_l[d]) begin
            chk("we_width", lowc[d], we_exp[d]);
            chk("wr_hold_addr", {15'd0, addr[d]}, {15'd0, sa[d]});
            chk("wr_hold_data", {24'd0, data[d]}, {24'd0, sd[d]});
          end
          p_s[d] = swe[d]; p_l[d] = lwe[d];
        end
        pa[d] = addr[d]; pd[d] = data[d];
      end
    end
  end

  initial begin
    int t0, t1, t2;
    n_rst    = 3'b000;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", {31'd0, in_ready[d]}, 32'd0);
      chk("rst_addr",  {15'd0, addr[d]}, 32'd0);
      chk("rst_data",  {24'd0, data[d]}, 32'd0);
      chk("rst_we",    {30'd0, swe[d], lwe[d]}, 32'd3);
      chk("rst_nboot", {31'd0, nb[d]}, 32'd1);
      chk("rst_err",   {31'd0, err[d]}, 32'd0);
    end

    // 2+2 bytes, WE=1, stall gap between bytes 2 and 3
    n_rst[0] = 1'b1;
    push(0, 1, 0, 8'h11); push(0, 1, 1, 8'h22); push(0, 0, 0, 8'h33); push(0, 0, 1, 8'h44);
    send_byte(0, 8'h11, t0);
    send_byte(0, 8'h22, t1);
    chk("byte_period_we1", t1 - t0, 4);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("gap_ready", {31'd0, in_ready[0]}, 32'd1);
      chk("gap_addr",  {15'd0, addr[0]}, 32'd1);
      chk("gap_data",  {24'd0, data[0]}, 32'h22);
      chk("gap_we",    {30'd0, swe[0], lwe[0]}, 32'd3);
      @(posedge clk);
      #1;
    end
    send_byte(0, 8'h33, t1);
    send_byte(0, 8'h44, t2);
    chk("byte_period_la", t2 - t1, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("nboot_in_hold", {31'd0, nb[0]}, 32'd1);
    @(posedge clk);
    #1;
`ifdef MLU_BOOT_CHECKSUM_EN
    chk("check_ready", {31'd0, in_ready[0]}, 32'd1);
    chk("check_nboot", {31'd0, nb[0]}, 32'd1);
    send_byte(0, 8'hAA, t0);
    chk("sum_ok_err", {31'd0, err[0]}, 32'd0);
`endif
    chk("nboot_done", {31'd0, nb[0]}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("done_ready", {31'd0, in_ready[0]}, 32'd0);
      chk("done_addr",  {15'd0, addr[0]}, 32'd1);
      chk("done_data",  {24'd0, data[0]}, 32'h44);
      chk("done_err",   {31'd0, err[0]}, 32'd0);
    end

    // Reset during the lookahead strobe of byte 3
    in_valid = 1'b0;
    n_rst[0] = 1'b0;
    @(posedge clk);
    #1;
    n_rst[0] = 1'b1;
    push(0, 1, 0, 8'h11); push(0, 1, 1, 8'h22);
    send_byte(0, 8'h11, t0);
    send_byte(0, 8'h22, t0);
    send_byte(0, 8'h33, t0);
    @(posedge clk);
    #1;
    chk("la_strobe_low", {31'd0, lwe[0]}, 32'd0);
    n_rst[0] = 1'b0;
    #1;
    chk("rst_mid_we",    {30'd0, swe[0], lwe[0]}, 32'd3);
    chk("rst_mid_nboot", {31'd0, nb[0]}, 32'd1);
    chk("rst_mid_addr",  {15'd0, addr[0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    push(0, 1, 0, 8'h5A);
    n_rst[0] = 1'b1;
    send_byte(0, 8'h5A, t0);
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_rst[0] = 1'b0;

`ifdef MLU_BOOT_CHECKSUM_EN
    // Wrong trailer
    @(posedge clk);
    #1;
    n_rst[0] = 1'b1;
    push(0, 1, 0, 8'h11); push(0, 1, 1, 8'h22); push(0, 0, 0, 8'h33); push(0, 0, 1, 8'h44);
    send_byte(0, 8'h11, t0);
    send_byte(0, 8'h22, t0);
    send_byte(0, 8'h33, t0);
    send_byte(0, 8'h44, t0);
    send_byte(0, 8'hAB, t0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sum_bad_err",   {31'd0, err[0]}, 32'd1);
    chk("sum_bad_nboot", {31'd0, nb[0]}, 32'd1);
    chk("sum_bad_ready", {31'd0, in_ready[0]}, 32'd0);
    n_rst[0] = 1'b0;
`endif

    // WE_CYCLES=3
    @(posedge clk);
    #1;
    n_rst[1] = 1'b1;
    push(1, 1, 0, 8'h11); push(1, 1, 1, 8'h22); push(1, 0, 0, 8'h33); push(1, 0, 1, 8'h44);
    send_byte(1, 8'h11, t0);
    send_byte(1, 8'h22, t0);
    send_byte(1, 8'h33, t1);
    send_byte(1, 8'h44, t2);
    chk("byte_period_we3", t2 - t1, 6);
`ifdef MLU_BOOT_CHECKSUM_EN
    send_byte(1, 8'hAA, t0);
`endif
    wait_booted(1);
    in_valid = 1'b0;
    n_rst[1] = 1'b0;

    // Empty slice phase: only the lookahead strobe may fire
    @(posedge clk);
    #1;
    n_rst[2] = 1'b1;
    push(2, 0, 0, 8'hAB);
    send_byte(2, 8'hAB, t0);
`ifdef MLU_BOOT_CHECKSUM_EN
    send_byte(2, 8'hAB, t0);
`endif
    wait_booted(2);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("last_addr_d2", {15'd0, addr[2]}, 32'd0);
    chk("last_data_d2", {24'd0, data[2]}, 32'hAB);
    chk("queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
